// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the LSU data memory: RISC-V funct3 size/sign codes,
// legal response-latency range, and the lane-mask / load-extension helpers
// used by dmem_lsu_ram.
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // Lane mask for a store. Halfwords use addr[1] only, so a misaligned
    // halfword naturally lands on the aligned-down pair of lanes.
    function automatic logic [3:0] byte_en(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (funct3)
            F3_B:    be = 4'b0001 << addr_lo;
            F3_H:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Right-align the addressed lane(s) of a RAM word and extend to 32 bits.
    function automatic logic [31:0] load_ext(input logic [2:0]  funct3,
                                             input logic [1:0]  addr_lo,
                                             input logic [31:0] word);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        sh  = word >> {addr_lo, 3'b000};
        b   = sh[7:0];
        h   = addr_lo[1] ? word[31:16] : word[15:0];
        res = 32'h0;
        case (funct3)
            F3_B:    res = {{24{b[7]}}, b};
            F3_BU:   res = {24'h0, b};
            F3_H:    res = {{16{h[15]}}, h};
            F3_HU:   res = {16'h0, h};
            F3_W:    res = word;
            default: res = 32'h0;
        endcase
        return res;
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
        if (we)
            return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return |addr_lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_rsp_pipe.sv
// -----------------------------------------------------------------------------
// dmem_rsp_pipe
// DEPTH-stage shift register carrying {valid, err, rdata} from acceptance to
// the response port. Reset clears every stage, so nothing in flight survives.
// Ports:
//   clk, rst            clock, async active-high reset
//   i_valid/i_err/i_rdata  response captured at the accepting edge
//   o_valid/o_err/o_rdata  response after DEPTH edges in total
// -----------------------------------------------------------------------------
module dmem_rsp_pipe #(
    parameter int DEPTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic        i_err,
    input  logic [31:0] i_rdata,
    output logic        o_valid,
    output logic        o_err,
    output logic [31:0] o_rdata
);

    logic        r_valid [DEPTH];
    logic        r_err   [DEPTH];
    logic [31:0] r_rdata [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_err[i]   <= 1'b0;
                r_rdata[i] <= 32'h0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_err[0]   <= i_err;
            r_rdata[0] <= i_rdata;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_err[i]   <= r_err[i-1];
                r_rdata[i] <= r_rdata[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_err   = r_err[DEPTH-1];
    assign o_rdata = r_rdata[DEPTH-1];

endmodule

// File: rtl/dmem_lsu_ram.sv
// -----------------------------------------------------------------------------
// dmem_lsu_ram
// Data memory behind the MEM stage: byte/half/word loads and stores with
// RISC-V extension, one request per cycle, in-order responses after RD_LAT
// cycles, access-fault reporting.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault
// instead of being silently aligned down.
// Ports:
//   clk, rst                  clock, async active-high reset
//   req_valid/req_ready       request handshake (ready is 1 from the first
//                             edge after reset release)
//   req_we, req_addr, req_funct3, req_wdata   request fields
//   rsp_valid, rsp_rdata, rsp_err             one-cycle response
// -----------------------------------------------------------------------------
module dmem_lsu_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 32,
    parameter int RD_LAT      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    // An out-of-range latency is clamped rather than left to build a broken pipe.
    localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    logic [31:0]      r_mem [DEPTH_WORDS];
    logic             r_ready;

    logic             w_accept;
    logic             w_oob;
    logic             w_illegal;
    logic             w_misalign;
    logic             w_err;
    logic             w_wr;
    logic [IDX_W-1:0] w_idx;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata_rep;
    logic [31:0]      w_word;
    logic [31:0]      w_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ready <= 1'b0;
        else     r_ready <= 1'b1;
    end

    assign req_ready = r_ready;
    assign w_accept  = req_valid && r_ready;
    assign w_idx     = req_addr[IDX_W+1:2];

    // Any set bit above the word index puts the access past the end of RAM.
    generate
        if (ADDR_W > IDX_W + 2) begin : g_oob
            assign w_oob = |req_addr[ADDR_W-1:IDX_W+2];
        end else begin : g_no_oob
            assign w_oob = 1'b0;
        end
    endgenerate

    assign w_illegal = !f3_legal(req_we, req_funct3);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = f3_misaligned(req_funct3, req_addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err = w_oob || w_illegal || w_misalign;
    assign w_wr  = w_accept && req_we && !w_err;
    assign w_be  = byte_en(req_funct3, req_addr[1:0]);

    // Replicate the right-aligned store data across lanes; the mask picks.
    always_comb begin
        w_wdata_rep = req_wdata;
        case (req_funct3[1:0])
            2'b00:   w_wdata_rep = {4{req_wdata[7:0]}};
            2'b01:   w_wdata_rep = {2{req_wdata[15:0]}};
            default: w_wdata_rep = req_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
            end
        end
    end

    // Read happens at the accepting edge, so it sees a store from the edge before.
    assign w_word  = r_mem[w_idx];
    assign w_rdata = (req_we || w_err) ? 32'h0 : load_ext(req_funct3, req_addr[1:0], w_word);

    dmem_rsp_pipe #(
        .DEPTH (LAT)
    ) u_rsp_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_accept),
        .i_err   (w_accept && w_err),
        .i_rdata (w_accept ? w_rdata : 32'h0),
        .o_valid (rsp_valid),
        .o_err   (rsp_err),
        .o_rdata (rsp_rdata)
    );

endmodule

// File: tb/tb_dmem_lsu_ram.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu_ram
// Two instances (RD_LAT=1 and RD_LAT=3) share one request stream. Each
// accepted request pushes its hand-computed response and due cycle onto a
// per-instance queue; responses are checked at the falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_lsu_ram;

    localparam int DEPTH = 256;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        int          at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [2:0]  req_funct3 = 3'b010;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] cur_rdata = 32'h0;
    logic        cur_err = 1'b0;

    logic        ready1, rsp1_valid, rsp1_err;
    logic [31:0] rsp1_rdata;
    logic        ready3, rsp3_valid, rsp3_err;
    logic [31:0] rsp3_rdata;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   seen1   = 0;
    int   seen3   = 0;
    exp_t q1[$];
    exp_t q3[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    dmem_lsu_ram #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1),
        .req_we(req_we), .req_addr(req_addr), .req_funct3(req_funct3),
        .req_wdata(req_wdata), .rsp_valid(rsp1_valid), .rsp_rdata(rsp1_rdata),
        .rsp_err(rsp1_err));

    dmem_lsu_ram #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready3),
        .req_we(req_we), .req_addr(req_addr), .req_funct3(req_funct3),
        .req_wdata(req_wdata), .rsp_valid(rsp3_valid), .rsp_rdata(rsp3_rdata),
        .rsp_err(rsp3_err));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: check/record at the falling edge, then return 1 after the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (rsp1_valid) begin
            seen1++;
            if (q1.size() == 0) chk("rsp1_unexpected", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                chk("rsp1_rdata", rsp1_rdata, e.rdata);
                chk("rsp1_err", {31'h0, rsp1_err}, {31'h0, e.err});
                chk("rsp1_cycle", cyc, e.at);
            end
        end
        if (rsp3_valid) begin
            seen3++;
            if (q3.size() == 0) chk("rsp3_unexpected", 32'd1, 32'd0);
            else begin
                e = q3.pop_front();
                chk("rsp3_rdata", rsp3_rdata, e.rdata);
                chk("rsp3_err", {31'h0, rsp3_err}, {31'h0, e.err});
                chk("rsp3_cycle", cyc, e.at);
            end
        end
        if (req_valid && ready1) q1.push_back('{rdata: cur_rdata, err: cur_err, at: cyc + 1});
        if (req_valid && ready3) q3.push_back('{rdata: cur_rdata, err: cur_err, at: cyc + 3});
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic issue(input vec_t v);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_addr   = v.addr;
        req_funct3 = v.f3;
        req_wdata  = v.wdata;
        cur_rdata  = v.rdata;
        cur_err    = v.err;
        step();
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic drain();
        req_valid = 1'b0;
        for (int i = 0; i < 12 && (q1.size() != 0 || q3.size() != 0); i++) step();
        chk("drain_q1_empty", q1.size(), 32'd0);
        chk("drain_q3_empty", q3.size(), 32'd0);
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                                input logic [31:0] wdata, input logic [31:0] rdata, input logic err);
        return '{we: we, addr: addr, f3: f3, wdata: wdata, rdata: rdata, err: err};
    endfunction

    initial begin
        // Reset behaviour
        repeat (3) step();
        chk("rst_ready1", {31'h0, ready1}, 32'd0);
        chk("rst_ready3", {31'h0, ready3}, 32'd0);
        chk("rst_rsp_valid", {30'h0, rsp1_valid, rsp3_valid}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_ready_before_edge", {30'h0, ready1, ready3}, 32'd0);
        step();
        chk("rel_ready_after_edge", {30'h0, ready1, ready3}, 32'h3);

        // Directed vectors, applied back to back
        vecs.push_back(mk(1, 32'h0,  3'b010, 32'h55AA55AA, 32'h0, 0));
        vecs.push_back(mk(1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 0));
        vecs.push_back(mk(0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 32'h20, 3'b010, 32'h0, 32'h0, 0));
        vecs.push_back(mk(1, 32'h22, 3'b000, 32'h12345680, 32'h0, 0));
        vecs.push_back(mk(0, 32'h20, 3'b010, 32'h0, 32'h00800000, 0));
        vecs.push_back(mk(0, 32'h22, 3'b000, 32'h0, 32'hFFFFFF80, 0));
        vecs.push_back(mk(0, 32'h22, 3'b100, 32'h0, 32'h00000080, 0));
        vecs.push_back(mk(1, 32'h30, 3'b010, 32'h11223344, 32'h0, 0));
        vecs.push_back(mk(1, 32'h32, 3'b001, 32'hABCD8001, 32'h0, 0));
        vecs.push_back(mk(0, 32'h30, 3'b010, 32'h0, 32'h80013344, 0));
        vecs.push_back(mk(0, 32'h32, 3'b001, 32'h0, 32'hFFFF8001, 0));
        vecs.push_back(mk(0, 32'h32, 3'b101, 32'h0, 32'h00008001, 0));
        vecs.push_back(mk(0, 32'h30, 3'b001, 32'h0, 32'h00003344, 0));
        vecs.push_back(mk(0, 32'h33, 3'b000, 32'h0, 32'hFFFFFF80, 0));
        vecs.push_back(mk(0, DEPTH * 4, 3'b010, 32'h0, 32'h0, 1));
        vecs.push_back(mk(1, DEPTH * 4, 3'b010, 32'hFFFFFFFF, 32'h0, 1));
        vecs.push_back(mk(0, 32'h0,  3'b010, 32'h0, 32'h55AA55AA, 0));
        vecs.push_back(mk(0, 32'h80000010, 3'b010, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 32'h10, 3'b011, 32'h0, 32'h0, 1));
        vecs.push_back(mk(1, 32'h10, 3'b011, 32'h0, 32'h0, 1));
        vecs.push_back(mk(1, 32'h10, 3'b100, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 32'h10, 3'b110, 32'h0, 32'h0, 1));
        vecs.push_back(mk(1, 32'h40, 3'b010, 32'h11223344, 32'h0, 0));
        vecs.push_back(mk(1, 32'h41, 3'b001, 32'h0000BEEF, 32'h0, TRAP));
        vecs.push_back(mk(0, 32'h40, 3'b010, 32'h0, TRAP ? 32'h11223344 : 32'h1122BEEF, 0));
        vecs.push_back(mk(0, 32'h12, 3'b010, 32'h0, TRAP ? 32'h0 : 32'hDEADBEEF, TRAP));
        vecs.push_back(mk(0, 32'h33, 3'b101, 32'h0, TRAP ? 32'h0 : 32'h00008001, TRAP));
        vecs.push_back(mk(0, 32'h3,  3'b100, 32'h0, 32'h00000055, 0));
        for (int i = 0; i < vecs.size(); i++) issue(vecs[i]);
        drain();

        // Streaming: 8 stores then 8 loads with valid held high
        for (int i = 0; i < 8; i++) issue(mk(1, i * 4, 3'b010, i, 32'h0, 0));
        for (int i = 0; i < 8; i++) issue(mk(0, i * 4, 3'b010, 32'h0, i, 0));
        drain();

        // Reset while loads are in flight
        issue(mk(1, 32'h60, 3'b010, 32'hCAFEF00D, 32'h0, 0));
        idle(4);
        issue(mk(0, 32'h60, 3'b010, 32'h0, 32'hCAFEF00D, 0));
        issue(mk(0, 32'h10, 3'b010, 32'h0, 32'h4, 0));
        req_valid = 1'b0;
        rst = 1'b1;
        q1.delete();
        q3.delete();
        #1;
        chk("midrst_rsp_cleared", {30'h0, rsp1_valid, rsp3_valid}, 32'd0);
        idle(3);
        chk("midrst_ready_low", {30'h0, ready1, ready3}, 32'd0);
        rst = 1'b0;
        seen1 = 0;
        seen3 = 0;
        idle(8);
        chk("midrst_no_rsp3", seen3, 32'd0);
        chk("midrst_no_rsp1", seen1, 32'd0);
        chk("midrst_ready_high", {30'h0, ready1, ready3}, 32'h3);
        issue(mk(0, 32'h60, 3'b010, 32'h0, 32'hCAFEF00D, 0));
        issue(mk(0, 32'h1C, 3'b010, 32'h0, 32'h7, 0));
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
